// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle instruction sequencer for the NPC core.
// Steps each instruction through fetch, execute, optional memory access and
// write-back, gates the decoder's register-file/PC write enables, halts the
// core on ebreak, illegal instruction, bus error or handshake timeout, and
// keeps the mcycle/minstret performance counters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | out of reset, no strobes; always moves on to FETCH
//   FETCH | ifu_req_valid held until the IFU accepts the request
//   IWAIT | waiting for the instruction word; ir_we on a clean response
//   EXEC  | decoder outputs sampled; selects halt, memory access or WB
//   MEM   | lsu_req_valid held (lsu_req_we = store flag) until accepted
//   DWAIT | waiting for load data / store completion from the LSU
//   WB    | reg_we (if the instruction writes a register), pc_we, retire
//   HALT  | core stopped; halted=1, cause held, stays here until rst
module npc_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic             ifu_rsp_err,
  output logic             ir_we,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_wreg,
  input  logic             dec_ebreak,
  input  logic             dec_illegal,
  output logic             lsu_req_valid,
  output logic             lsu_req_we,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic             lsu_rsp_err,
  output logic             reg_we,
  output logic             pc_we,
  output logic             retire,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] mcycle,
  output logic [CNT_W-1:0] minstret
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_IWAIT = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_DWAIT = 3'd5,
    S_WB    = 3'd6,
    S_HALT  = 3'd7
  } state_e;

  localparam logic [1:0] CAUSE_EBREAK  = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // The wait timer is a down-counter: loaded with TIMEOUT-1 on entry to a
  // handshake state, so it hits zero in the TIMEOUT-th cycle spent there.
  localparam int unsigned     TMR_W    = 16;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               st_q, st_d;
  logic               wr_q, wr_d;
  logic [1:0]         cause_q, cause_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   mcycle_q, mcycle_d;
  logic [CNT_W-1:0]   minstret_q, minstret_d;
  logic               tmr_tc;

  function automatic logic is_wait(input state_e s);
    return (s == S_FETCH) || (s == S_IWAIT) || (s == S_MEM) || (s == S_DWAIT);
  endfunction

  assign tmr_tc = (tmr_q == '0);

  // State register, instruction flags, halt cause, wait timer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      st_q       <= 1'b0;
      wr_q       <= 1'b0;
      cause_q    <= 2'd0;
      tmr_q      <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      wr_q       <= wr_d;
      cause_q    <= cause_d;
      tmr_q      <= tmr_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Next-state logic; a completed handshake always takes precedence over
  // a timeout raised in the same cycle.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    wr_d    = wr_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_req_ready) begin
          state_d = S_IWAIT;
        end else if (tmr_tc) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_IWAIT: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = S_HALT;
            cause_d = CAUSE_BUSERR;
          end else begin
            state_d = S_EXEC;
          end
        end else if (tmr_tc) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXEC: begin
        if (dec_illegal) begin
          state_d = S_HALT;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_ebreak) begin
          state_d = S_HALT;
          cause_d = CAUSE_EBREAK;
        end else if (dec_load || dec_store) begin
          st_d    = dec_store;
          wr_d    = dec_wreg;
          state_d = S_MEM;
        end else begin
          wr_d    = dec_wreg;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_req_ready) begin
          state_d = S_DWAIT;
        end else if (tmr_tc) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DWAIT: begin
        if (lsu_rsp_valid) begin
          if (lsu_rsp_err) begin
            state_d = S_HALT;
            cause_d = CAUSE_BUSERR;
          end else begin
            state_d = S_WB;
          end
        end else if (tmr_tc) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Wait timer: reload on entry to a handshake state, count down while
  // staying in it; holds at zero otherwise.
  always_comb begin
    tmr_d = tmr_q;
    if ((state_d != state_q) && is_wait(state_d)) begin
      tmr_d = TMR_LOAD;
    end else if ((state_d == state_q) && is_wait(state_q) && !tmr_tc) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  // Output decodes. ir_we and the ebreak retire are qualified by the
  // inputs sampled in the same cycle; everything else follows the state.
  always_comb begin
    ifu_req_valid = 1'b0;
    ir_we         = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_we    = 1'b0;
    reg_we        = 1'b0;
    pc_we         = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: ifu_req_valid = 1'b1;
      S_IWAIT: ir_we = ifu_rsp_valid && !ifu_rsp_err;
      S_EXEC:  retire = dec_ebreak && !dec_illegal;
      S_MEM: begin
        lsu_req_valid = 1'b1;
        lsu_req_we    = st_q;
      end
      S_WB: begin
        reg_we = wr_q;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Performance counters; mcycle freezes once the core has halted.
  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    if (state_q != S_HALT) begin
      mcycle_d = mcycle_q + CNT_W'(1);
    end
    if (retire) begin
      minstret_d = minstret_q + CNT_W'(1);
    end
  end

  assign halt_cause = cause_q;
  assign state      = state_q;
  assign mcycle     = mcycle_q;
  assign minstret   = minstret_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Bench for npc_seq_ctrl: per-cycle vector table with a scoreboard queue
// and a small counter model, plus a hand-written retire-spacing check.
module tb_npc_seq_ctrl;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ir_we;
  logic          dec_load, dec_store, dec_wreg, dec_ebreak, dec_illegal;
  logic          lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic          reg_we, pc_we, retire, halted;
  logic [1:0]    halt_cause;
  logic [2:0]    state;
  logic [CW-1:0] mcycle, minstret;

  npc_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ir_we(ir_we),
    .dec_load(dec_load), .dec_store(dec_store), .dec_wreg(dec_wreg),
    .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_err(lsu_rsp_err),
    .reg_we(reg_we), .pc_we(pc_we), .retire(retire), .halted(halted),
    .halt_cause(halt_cause), .state(state), .mcycle(mcycle), .minstret(minstret)
  );

  always #5 clk = ~clk;

  // Input bits
  localparam logic [11:0] I_RST  = 12'h800, I_IRDY = 12'h400, I_IRV = 12'h200,
                          I_IERR = 12'h100, I_LD   = 12'h080, I_ST  = 12'h040,
                          I_WR   = 12'h020, I_EB   = 12'h010, I_IL  = 12'h008,
                          I_LRDY = 12'h004, I_LRV  = 12'h002, I_LERR = 12'h001;
  // Output bits: {ifu_req_valid, ir_we, lsu_req_valid, lsu_req_we, reg_we, pc_we, retire, halted}
  localparam logic [7:0] O_IRV = 8'h80, O_IRW = 8'h40, O_LRV = 8'h20, O_LWE = 8'h10,
                         O_RWE = 8'h08, O_PWE = 8'h04, O_RET = 8'h02, O_HLT = 8'h01;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_IWAIT = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_DWAIT = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;
  localparam logic [7:0] O_WBW = O_RWE | O_PWE | O_RET;
  localparam logic [11:0] Z = I_IRDY | I_IRV | I_WR | I_LRDY | I_LRV;

  typedef struct packed {
    logic [11:0] in;
    logic [2:0]  st;
    logic [7:0]  out;
    logic [1:0]  cause;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic [7:0]  out;
    logic [1:0]  cause;
    logic [CW-1:0] mc;
    logic [CW-1:0] mi;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  logic [CW-1:0] m_mc, m_mi;

  task automatic add(input logic [11:0] in, input logic [2:0] st,
                     input logic [7:0] out, input logic [1:0] cause);
    vec_t v;
    v.in = in; v.st = st; v.out = out; v.cause = cause;
    vecs.push_back(v);
  endtask

  task automatic addn(input int n, input logic [11:0] in, input logic [2:0] st,
                      input logic [7:0] out, input logic [1:0] cause);
    for (int k = 0; k < n; k++) add(in, st, out, cause);
  endtask

  task automatic drive(input logic [11:0] in);
    rst           = in[11];
    ifu_req_ready = in[10];
    ifu_rsp_valid = in[9];
    ifu_rsp_err   = in[8];
    dec_load      = in[7];
    dec_store     = in[6];
    dec_wreg      = in[5];
    dec_ebreak    = in[4];
    dec_illegal   = in[3];
    lsu_req_ready = in[2];
    lsu_rsp_valid = in[1];
    lsu_rsp_err   = in[0];
  endtask

  function automatic logic [7:0] obs();
    return {ifu_req_valid, ir_we, lsu_req_valid, lsu_req_we, reg_we, pc_we, retire, halted};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, g;
    int cyc, t1, t2;

    // Zero-wait ALU stream: retire at cycles 5, 9, 13; minstret=3 at 14
    add(I_RST, S_IDLE, 8'h00, 2'd0);
    add(Z, S_IDLE, 8'h00, 2'd0);
    for (int k = 0; k < 3; k++) begin
      add(Z, S_FETCH, O_IRV, 2'd0);
      add(Z, S_IWAIT, O_IRW, 2'd0);
      add(Z, S_EXEC, 8'h00, 2'd0);
      add(Z, S_WB, O_WBW, 2'd0);
    end
    add(Z, S_FETCH, O_IRV, 2'd0);
    // Load: ready after 3 idle MEM cycles, response 2 cycles after transfer
    add(I_RST, S_IWAIT, 8'h00, 2'd0);
    add(12'h0, S_IDLE, 8'h00, 2'd0);
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_LD | I_WR, S_EXEC, 8'h00, 2'd0);
    addn(3, 12'h0, S_MEM, O_LRV, 2'd0);
    add(I_LRDY, S_MEM, O_LRV, 2'd0);
    add(12'h0, S_DWAIT, 8'h00, 2'd0);
    add(I_LRV, S_DWAIT, 8'h00, 2'd0);
    add(12'h0, S_WB, O_WBW, 2'd0);
    add(12'h0, S_FETCH, O_IRV, 2'd0);
    // Store without register write
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_ST, S_EXEC, 8'h00, 2'd0);
    add(I_LRDY, S_MEM, O_LRV | O_LWE, 2'd0);
    add(I_LRV, S_DWAIT, 8'h00, 2'd0);
    add(12'h0, S_WB, O_PWE | O_RET, 2'd0);
    add(12'h0, S_FETCH, O_IRV, 2'd0);
    // ebreak: retire in EXEC, then 20 halted cycles with everything offered
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_EB, S_EXEC, O_RET, 2'd0);
    addn(20, I_IRDY | I_IRV | I_LRDY | I_LRV, S_HALT, O_HLT, 2'd0);
    // illegal beats ebreak and load; no retire
    add(I_RST, S_HALT, O_HLT, 2'd0);
    add(12'h0, S_IDLE, 8'h00, 2'd0);
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_IL | I_EB | I_LD, S_EXEC, 8'h00, 2'd0);
    addn(2, 12'h0, S_HALT, O_HLT, 2'd1);
    // FETCH timeout after 8 wait cycles; rsp_valid ignored in FETCH
    add(I_RST, S_HALT, O_HLT, 2'd1);
    add(12'h0, S_IDLE, 8'h00, 2'd0);
    add(I_IRV, S_FETCH, O_IRV, 2'd0);
    addn(7, 12'h0, S_FETCH, O_IRV, 2'd0);
    add(I_IRDY, S_HALT, O_HLT, 2'd3);
    add(12'h0, S_HALT, O_HLT, 2'd3);
    // Handshakes completing on the 8th wait cycle win; timer reloads per state
    add(I_RST, S_HALT, O_HLT, 2'd3);
    add(12'h0, S_IDLE, 8'h00, 2'd0);
    addn(7, 12'h0, S_FETCH, O_IRV, 2'd0);
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    addn(7, 12'h0, S_IWAIT, 8'h00, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_WR, S_EXEC, 8'h00, 2'd0);
    add(12'h0, S_WB, O_WBW, 2'd0);
    add(12'h0, S_FETCH, O_IRV, 2'd0);
    // DWAIT timeout
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_LD, S_EXEC, 8'h00, 2'd0);
    add(I_LRDY, S_MEM, O_LRV, 2'd0);
    addn(8, 12'h0, S_DWAIT, 8'h00, 2'd0);
    add(12'h0, S_HALT, O_HLT, 2'd3);
    // Data bus error: cause 2, no retire
    add(I_RST, S_HALT, O_HLT, 2'd3);
    add(12'h0, S_IDLE, 8'h00, 2'd0);
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_LD | I_WR, S_EXEC, 8'h00, 2'd0);
    add(I_LRDY, S_MEM, O_LRV, 2'd0);
    add(I_LRV | I_LERR, S_DWAIT, 8'h00, 2'd0);
    addn(2, 12'h0, S_HALT, O_HLT, 2'd2);
    // Fetch bus error: no ir_we, cause 2
    add(I_RST, S_HALT, O_HLT, 2'd2);
    add(12'h0, S_IDLE, 8'h00, 2'd0);
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV | I_IERR, S_IWAIT, 8'h00, 2'd0);
    add(12'h0, S_HALT, O_HLT, 2'd2);
    // Reset mid-DWAIT, stale LSU response ignored, fetch resumes
    add(I_RST, S_HALT, O_HLT, 2'd2);
    add(12'h0, S_IDLE, 8'h00, 2'd0);
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_LD | I_WR, S_EXEC, 8'h00, 2'd0);
    add(I_LRDY, S_MEM, O_LRV, 2'd0);
    add(12'h0, S_DWAIT, 8'h00, 2'd0);
    add(I_RST, S_DWAIT, 8'h00, 2'd0);
    add(I_LRV, S_IDLE, 8'h00, 2'd0);
    add(I_LRV, S_FETCH, O_IRV, 2'd0);
    add(I_IRDY, S_FETCH, O_IRV, 2'd0);
    add(I_IRV, S_IWAIT, O_IRW, 2'd0);
    add(I_WR, S_EXEC, 8'h00, 2'd0);
    add(12'h0, S_WB, O_WBW, 2'd0);
    add(12'h0, S_FETCH, O_IRV, 2'd0);

    drive(I_RST);
    repeat (2) @(posedge clk);
    m_mc = '0;
    m_mi = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].in);
      e.idx = i; e.st = vecs[i].st; e.out = vecs[i].out; e.cause = vecs[i].cause;
      e.mc = m_mc; e.mi = m_mi;
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      n_vec++;
      if ({state, obs(), halt_cause, mcycle, minstret} !== {g.st, g.out, g.cause, g.mc, g.mi}) begin
        n_err++;
        $display("FAIL vec[%0d]: got state=%0d out=%b cause=%0d mcycle=%0d minstret=%0d, want state=%0d out=%b cause=%0d mcycle=%0d minstret=%0d",
                 g.idx, state, obs(), halt_cause, mcycle, minstret, g.st, g.out, g.cause, g.mc, g.mi);
      end
      if (vecs[i].in[11]) begin
        m_mc = '0;
        m_mi = '0;
      end else begin
        if (vecs[i].st != S_HALT) m_mc = m_mc + 1;
        if (vecs[i].out[1]) m_mi = m_mi + 1;
      end
    end

    // Retire spacing under zero-wait units, bounded wait
    @(posedge clk); #1;
    drive(I_RST | Z);
    @(posedge clk); #1;
    drive(Z);
    cyc = 0; t1 = -1; t2 = -1;
    for (int k = 0; k < 30 && t2 < 0; k++) begin
      @(negedge clk);
      cyc++;
      if (retire) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    n_vec++;
    if (t1 != 5) begin
      n_err++;
      $display("FAIL first_retire_cycle: got %0d, want 5", t1);
    end
    n_vec++;
    if (t2 < 0 || (t2 - t1) != 4) begin
      n_err++;
      $display("FAIL retire_spacing: got second at %0d (first %0d), want spacing 4", t2, t1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
